// File: rtl/weight_load_sequencer_pkg.sv
// ----------------------------------------------------------------------------
// weight_load_sequencer_pkg
// Shared definitions for the weight load/run sequencer: FSM state encoding,
// default geometry of the three base-classifier weight memories, and a small
// helper used to size counters.
// ----------------------------------------------------------------------------
package weight_load_sequencer_pkg;

    localparam int DEPTH_DEF   = 32;   // words per weight memory
    localparam int AW_DEF      = 5;    // address width
    localparam int WW_DEF      = 9;    // signed weight width
    localparam int TIMEOUT_DEF = 255;  // max cycles waiting for the stacked result
    localparam int NMEM        = 3;    // number of base-classifier memories
    localparam int MW          = $clog2(NMEM);  // memory index width

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOAD     = 2'd1,
        ST_RUN      = 2'd2,
        ST_WAIT_RES = 2'd3
    } state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/weight_load_sequencer_seq_addr_counter.sv
// ----------------------------------------------------------------------------
// seq_addr_counter
// W-bit up counter with synchronous clear (priority over enable) and a
// terminal-count flag raised while the count equals LAST. Wrapping is done by
// the owner asserting i_clr together with i_en on the terminal count, which
// lets the same counter also run past LAST when used as a timer.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_clr          : clear to zero on the next edge
//   i_en           : increment on the next edge
//   o_cnt          : current count
//   o_tc           : o_cnt == LAST
// ----------------------------------------------------------------------------
module seq_addr_counter #(
    parameter int W    = 5,
    parameter int LAST = 31
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == W'(LAST));

endmodule

// File: rtl/weight_load_sequencer.sv
// ----------------------------------------------------------------------------
// weight_load_sequencer
// Drives the shared address/datain and per-memory read/write strobes of the
// three base-classifier weight memories.
//   LOAD: streams 3*DEPTH signed weights from a valid/ready source into
//         memories 1,2,3 in order.
//   RUN : sweeps DEPTH synchronous reads with the classifier enable high, then
//         waits (bounded by TIMEOUT) for the stacked final result.
// Ports:
//   i_clk, i_rst_n     : clock, asynchronous active-low reset
//   i_load_start       : pulse, begin LOAD
//   i_run_start        : pulse, begin RUN (error if nothing loaded)
//   i_load_valid/_data : weight source; o_load_ready is the accept handshake
//   o_mem_wdata        : shared datain to all memories
//   o_mem_addr         : shared address to all memories
//   o_mem_write        : per-memory write strobe, bit k = memory k+1
//   o_mem_read         : per-memory read strobe
//   o_cls_en           : base classifier enable
//   i_total_ready      : final_ready from the logistic stage
//   o_loaded           : all 3*DEPTH words written since reset
//   o_busy             : not idle
//   o_load_done, o_run_done, o_err : one-cycle status pulses
// All outputs are registered.
// ----------------------------------------------------------------------------
module weight_load_sequencer
    import weight_load_sequencer_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int AW      = AW_DEF,
    parameter int WW      = WW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF   // must be >= 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_load_start,
    input  logic                 i_run_start,
    input  logic                 i_load_valid,
    input  logic signed [WW-1:0] i_load_data,
    output logic                 o_load_ready,
    output logic signed [WW-1:0] o_mem_wdata,
    output logic [AW-1:0]        o_mem_addr,
    output logic [NMEM-1:0]      o_mem_write,
    output logic [NMEM-1:0]      o_mem_read,
    output logic                 o_cls_en,
    input  logic                 i_total_ready,
    output logic                 o_loaded,
    output logic                 o_busy,
    output logic                 o_load_done,
    output logic                 o_run_done,
    output logic                 o_err
);

    // The read counter doubles as the WAIT_RES timer, so it must hold TIMEOUT.
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int CW = max_int(AW, TW);

    state_t r_state, w_state_next;

    logic [MW-1:0]        r_midx;
    logic                 r_load_ready, r_cls_en, r_loaded, r_busy;
    logic                 r_load_done, r_run_done, r_err;
    logic signed [WW-1:0] r_mem_wdata;
    logic [AW-1:0]        r_mem_addr;
    logic [NMEM-1:0]      r_mem_write, r_mem_read;

    logic                 w_accept, w_load_last, w_issue_rd;
    logic                 w_err_next, w_run_done_next, w_load_done_next;
    logic signed [WW-1:0] w_mem_wdata_next;
    logic [AW-1:0]        w_mem_addr_next;
    logic [NMEM-1:0]      w_mem_write_next;
    logic [AW-1:0]        w_wcnt;
    logic                 w_wcnt_tc, w_wcnt_clr;
    logic [CW-1:0]        w_rcnt;
    logic                 w_rcnt_tc, w_rcnt_clr, w_rcnt_en;

    assign w_accept    = (r_state == ST_LOAD) && i_load_valid && r_load_ready;
    assign w_load_last = w_wcnt_tc && (r_midx == MW'(NMEM - 1));

    // Word counter: wraps to 0 after DEPTH-1, held at 0 outside LOAD.
    assign w_wcnt_clr = (r_state != ST_LOAD) || (w_accept && w_wcnt_tc);

    seq_addr_counter #(.W(AW), .LAST(DEPTH - 1)) u_wcnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_wcnt_clr),
        .i_en    (w_accept),
        .o_cnt   (w_wcnt),
        .o_tc    (w_wcnt_tc)
    );

    // Read address / timer: zero whenever heading to IDLE so a following
    // run_start reads address 0, and zeroed again on entry to WAIT_RES so it
    // then counts waiting cycles.
    assign w_rcnt_clr = (w_state_next == ST_IDLE) ||
                        ((w_state_next == ST_WAIT_RES) && (r_state != ST_WAIT_RES));
    assign w_rcnt_en  = w_issue_rd || (r_state == ST_WAIT_RES);

    seq_addr_counter #(.W(CW), .LAST(DEPTH - 1)) u_rcnt (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_rcnt_clr),
        .i_en    (w_rcnt_en),
        .o_cnt   (w_rcnt),
        .o_tc    (w_rcnt_tc)
    );

    // Next-state and status pulses. The first read is issued on the edge that
    // samples run_start, so IDLE also issues reads.
    always_comb begin
        w_state_next     = r_state;
        w_issue_rd       = 1'b0;
        w_err_next       = 1'b0;
        w_run_done_next  = 1'b0;
        w_load_done_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_load_start) begin
                    w_state_next = ST_LOAD;           // wins over run_start
                end else if (i_run_start) begin
                    if (r_loaded) begin
                        w_issue_rd   = 1'b1;
                        w_state_next = w_rcnt_tc ? ST_WAIT_RES : ST_RUN;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (w_accept && w_load_last) begin
                    w_state_next     = ST_IDLE;
                    w_load_done_next = 1'b1;
                end
            end
            ST_RUN: begin
                w_issue_rd = 1'b1;
                if (w_rcnt_tc) begin
                    w_state_next = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                if (i_total_ready) begin
                    w_state_next    = ST_IDLE;
                    w_run_done_next = 1'b1;
                end else if (w_rcnt == CW'(TIMEOUT - 1)) begin
                    w_state_next = ST_IDLE;
                    w_err_next   = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Address and data hold their last value when neither reading nor writing.
    always_comb begin
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        if (w_issue_rd) begin
            w_mem_addr_next = w_rcnt[AW-1:0];
        end else if (w_accept) begin
            w_mem_addr_next  = w_wcnt;
            w_mem_wdata_next = i_load_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NMEM; gi++) begin : g_wr
            assign w_mem_write_next[gi] = w_accept && (r_midx == MW'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_midx       <= '0;
            r_load_ready <= 1'b0;
            r_mem_wdata  <= '0;
            r_mem_addr   <= '0;
            r_mem_write  <= '0;
            r_mem_read   <= '0;
            r_cls_en     <= 1'b0;
            r_loaded     <= 1'b0;
            r_busy       <= 1'b0;
            r_load_done  <= 1'b0;
            r_run_done   <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            if (r_state != ST_LOAD) begin
                r_midx <= '0;
            end else if (w_accept && w_wcnt_tc) begin
                r_midx <= r_midx + 1'b1;
            end
            r_load_ready <= (w_state_next == ST_LOAD);
            r_mem_wdata  <= w_mem_wdata_next;
            r_mem_addr   <= w_mem_addr_next;
            r_mem_write  <= w_mem_write_next;
            r_mem_read   <= {NMEM{w_issue_rd}};
            r_cls_en     <= w_issue_rd;
            r_loaded     <= r_loaded | w_load_done_next;
            r_busy       <= (w_state_next != ST_IDLE);
            r_load_done  <= w_load_done_next;
            r_run_done   <= w_run_done_next;
            r_err        <= w_err_next;
        end
    end

    assign o_load_ready = r_load_ready;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_write  = r_mem_write;
    assign o_mem_read   = r_mem_read;
    assign o_cls_en     = r_cls_en;
    assign o_loaded     = r_loaded;
    assign o_busy       = r_busy;
    assign o_load_done  = r_load_done;
    assign o_run_done   = r_run_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_weight_load_sequencer.sv
// ----------------------------------------------------------------------------
// tb_weight_load_sequencer
// Directed scenarios for weight_load_sequencer with hand-computed expectations.
// Outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_weight_load_sequencer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_start, run_start, load_valid, total_ready;
    logic signed [8:0] load_data;
    logic              load_ready, cls_en, loaded, busy, load_done, run_done, err;
    logic signed [8:0] mem_wdata;
    logic [4:0]        mem_addr;
    logic [2:0]        mem_write, mem_read;

    int n_checks = 0;
    int n_fail   = 0;

    weight_load_sequencer dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_load_start  (load_start),
        .i_run_start   (run_start),
        .i_load_valid  (load_valid),
        .i_load_data   (load_data),
        .o_load_ready  (load_ready),
        .o_mem_wdata   (mem_wdata),
        .o_mem_addr    (mem_addr),
        .o_mem_write   (mem_write),
        .o_mem_read    (mem_read),
        .o_cls_en      (cls_en),
        .i_total_ready (total_ready),
        .o_loaded      (loaded),
        .o_busy        (busy),
        .o_load_done   (load_done),
        .o_run_done    (run_done),
        .o_err         (err)
    );

    always #5 clk = ~clk;

    // {load_ready, mem_write, mem_read, cls_en, loaded, busy, load_done, run_done, err}
    function automatic logic [12:0] flags();
        return {load_ready, mem_write, mem_read, cls_en, loaded, busy, load_done, run_done, err};
    endfunction

    task automatic test_reset();
        rst_n = 1'b1; load_start = 0; run_start = 0; load_valid = 0;
        load_data = '0; total_ready = 0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (flags() !== 13'd0) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 0", flags());
        end
        n_checks++;
        if ({mem_addr, mem_wdata} !== 14'd0) begin
            n_fail++; $display("FAIL reset_addr_data: got addr %0d data %0d expected 0/0", mem_addr, mem_wdata);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (flags() !== 13'd0) begin
            n_fail++; $display("FAIL idle_after_reset: got %b expected 0", flags());
        end
        $display("reset: done");
    endtask

    task automatic test_full_load();
        logic [2:0]        exp_wr;
        logic signed [8:0] exp_d;
        load_start = 1; @(posedge clk); #1 load_start = 0;
        n_checks++;
        if ({load_ready, busy} !== 2'b11) begin
            n_fail++; $display("FAIL load_enter: ready/busy got %b expected 11", {load_ready, busy});
        end
        load_valid = 1;
        for (int i = 0; i < 96; i++) begin
            load_data = 9'(i - 48);
            @(posedge clk); #1;
            exp_wr = 3'(1 << (i / 32));
            exp_d  = 9'(i - 48);
            $display("load write %0d: mem_write=%b addr=%0d data=%0d", i, mem_write, mem_addr, mem_wdata);
            n_checks++;
            if ({mem_write, mem_read} !== {exp_wr, 3'b000}) begin
                n_fail++; $display("FAIL load_strobe[%0d]: got %b expected %b", i, {mem_write, mem_read}, {exp_wr, 3'b000});
            end
            n_checks++;
            if (mem_addr !== 5'(i % 32) || mem_wdata !== exp_d) begin
                n_fail++; $display("FAIL load_addr_data[%0d]: got %0d/%0d expected %0d/%0d", i, mem_addr, mem_wdata, i % 32, exp_d);
            end
            n_checks++;
            if ({load_done, loaded, load_ready} !== ((i == 95) ? 3'b110 : 3'b001)) begin
                n_fail++; $display("FAIL load_status[%0d]: done/loaded/ready got %b", i, {load_done, loaded, load_ready});
            end
        end
        load_valid = 0;
        @(posedge clk); #1;
        n_checks++;
        if ({load_done, loaded, busy, mem_write, load_ready} !== 7'b0100000) begin
            n_fail++; $display("FAIL load_after: done/loaded/busy/wr/ready got %b expected 0100000", {load_done, loaded, busy, mem_write, load_ready});
        end
    endtask

    task automatic test_valid_gaps();
        logic [2:0] exp_wr;
        load_start = 1; @(posedge clk); #1 load_start = 0;
        for (int i = 0; i < 96; i++) begin
            load_valid = 1; load_data = 9'(2 * i - 96);
            @(posedge clk); #1;
            exp_wr = 3'(1 << (i / 32));
            n_checks++;
            if (mem_write !== exp_wr || mem_addr !== 5'(i % 32) || mem_wdata !== 9'(2 * i - 96)) begin
                n_fail++; $display("FAIL gap_write[%0d]: got wr %b addr %0d data %0d expected %b %0d %0d", i, mem_write, mem_addr, mem_wdata, exp_wr, i % 32, 2 * i - 96);
            end
            n_checks++;
            if (load_done !== (i == 95)) begin
                n_fail++; $display("FAIL gap_done[%0d]: got %b", i, load_done);
            end
            load_valid = 0; load_data = 9'sd77;
            @(posedge clk); #1;
            n_checks++;
            if (mem_write !== 3'b000 || mem_addr !== 5'(i % 32)) begin
                n_fail++; $display("FAIL gap_idle[%0d]: got wr %b addr %0d expected 000 %0d", i, mem_write, mem_addr, i % 32);
            end
        end
        n_checks++;
        if ({loaded, busy, load_ready} !== 3'b100) begin
            n_fail++; $display("FAIL gap_end: loaded/busy/ready got %b expected 100", {loaded, busy, load_ready});
        end
        $display("valid gaps: 96 beats");
    endtask

    task automatic test_run_sweep();
        run_start = 1; @(posedge clk); #1 run_start = 0;
        for (int k = 0; k < 32; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            $display("run read %0d: mem_read=%b addr=%0d cls_en=%b", k, mem_read, mem_addr, cls_en);
            n_checks++;
            if ({mem_read, mem_write, cls_en, busy} !== 8'b11100011 || mem_addr !== 5'(k)) begin
                n_fail++; $display("FAIL sweep[%0d]: rd/wr/cls/busy %b addr %0d expected 11100011 %0d", k, {mem_read, mem_write, cls_en, busy}, mem_addr, k);
            end
            // total_ready during RUN must be ignored
            total_ready = (k == 10);
        end
        total_ready = 0;
        @(posedge clk); #1;
        n_checks++;
        if ({mem_read, cls_en, busy, run_done} !== 6'b000010 || mem_addr !== 5'd31) begin
            n_fail++; $display("FAIL sweep_end: rd/cls/busy/done %b addr %0d expected 000010 31", {mem_read, cls_en, busy, run_done}, mem_addr);
        end
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, run_done} !== 2'b10) begin
            n_fail++; $display("FAIL wait_res: busy/done got %b expected 10", {busy, run_done});
        end
        total_ready = 1;
        @(posedge clk); #1 total_ready = 0;
        n_checks++;
        if ({run_done, busy, err} !== 3'b100) begin
            n_fail++; $display("FAIL run_done: done/busy/err got %b expected 100", {run_done, busy, err});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({run_done, busy} !== 2'b00) begin
            n_fail++; $display("FAIL run_done_pulse: done/busy got %b expected 00", {run_done, busy});
        end
    endtask

    task automatic test_reset_mid_load();
        load_start = 1; @(posedge clk); #1 load_start = 0;
        load_valid = 1;
        for (int i = 0; i < 40; i++) begin
            load_data = 9'(i - 48);
            @(posedge clk); #1;
        end
        load_valid = 0;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (flags() !== 13'd0 || {mem_addr, mem_wdata} !== 14'd0) begin
            n_fail++; $display("FAIL async_reset: flags %b addr %0d data %0d expected all 0", flags(), mem_addr, mem_wdata);
        end
        @(negedge clk) rst_n = 1'b1;
        run_start = 1; @(posedge clk); #1 run_start = 0;
        n_checks++;
        if ({err, mem_read, cls_en, busy, loaded} !== 7'b1000000) begin
            n_fail++; $display("FAIL unloaded_run: err/rd/cls/busy/loaded got %b expected 1000000", {err, mem_read, cls_en, busy, loaded});
        end
        @(posedge clk); #1;
        n_checks++;
        if ({err, mem_read} !== 4'b0000) begin
            n_fail++; $display("FAIL unloaded_run_pulse: err/rd got %b expected 0000", {err, mem_read});
        end
        $display("reset mid-load: done");
    endtask

    task automatic test_simultaneous_timeout();
        int found;
        load_start = 1; run_start = 1;
        @(posedge clk); #1 load_start = 0; run_start = 0;
        n_checks++;
        if ({err, busy, load_ready, mem_read} !== 6'b011000) begin
            n_fail++; $display("FAIL both_starts: err/busy/ready/rd got %b expected 011000", {err, busy, load_ready, mem_read});
        end
        load_valid = 1;
        for (int i = 0; i < 96; i++) begin
            load_data  = 9'(95 - i);
            load_start = (i == 50);
            run_start  = (i == 50);
            @(posedge clk); #1;
            n_checks++;
            if (err !== 1'b0 || mem_addr !== 5'(i % 32)) begin
                n_fail++; $display("FAIL load_ignore_start[%0d]: err %b addr %0d expected 0 %0d", i, err, mem_addr, i % 32);
            end
        end
        load_valid = 0; load_start = 0; run_start = 0;
        n_checks++;
        if ({loaded, load_done} !== 2'b11) begin
            n_fail++; $display("FAIL reload_done: loaded/done got %b expected 11", {loaded, load_done});
        end
        run_start = 1; @(posedge clk); #1 run_start = 0;
        repeat (31) @(posedge clk);
        #1;
        n_checks++;
        if (mem_read !== 3'b111 || mem_addr !== 5'd31) begin
            n_fail++; $display("FAIL timeout_last_read: rd %b addr %0d expected 111 31", mem_read, mem_addr);
        end
        found = 0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk); #1;
            if (err === 1'b1) begin
                found = n;
                break;
            end
        end
        $display("timeout: err after %0d wait cycles", found);
        n_checks++;
        if (found !== 255) begin
            n_fail++; $display("FAIL timeout_cycles: got %0d expected 255", found);
        end
        n_checks++;
        if ({busy, run_done, mem_read} !== 5'b00000) begin
            n_fail++; $display("FAIL timeout_idle: busy/done/rd got %b expected 00000", {busy, run_done, mem_read});
        end
        @(posedge clk); #1;
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL timeout_err_pulse: got %b expected 0", err);
        end
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_valid_gaps();
        test_run_sweep();
        test_reset_mid_load();
        test_simultaneous_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
